// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage; main register plus skid register when PIPE_STAGE_SKID_EN is defined.
// Latency: 1 cycle from acceptance to out_* whenever main is empty or retiring.
// Backpressure: skid build gives a registered in_ready (= !skid_full); single-entry build gives in_ready = !out_valid || out_ready.
module pipe_stage_reg #(
   parameter int          PAYLOAD_W    = 102,
   parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [31:0]          in_pc,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [31:0]          out_pc,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           occupancy
);

   typedef struct packed {
      logic [31:0]          instr;
      logic [31:0]          pc;
      logic [PAYLOAD_W-1:0] data;
   } entry_t;

   entry_t in_ent;
   entry_t main_q;
   entry_t main_d;
   logic   main_vld;
   logic   main_vld_d;
   logic   accept;
   logic   main_free;

   assign in_ent    = {in_instr, in_pc, in_data};
   assign accept    = in_valid && in_ready;
   assign main_free = !main_vld || out_ready;

`ifdef PIPE_STAGE_SKID_EN
   entry_t skid_q;
   entry_t skid_d;
   logic   skid_vld;
   logic   skid_vld_d;
   logic   rdy_q;

   // in_ready comes straight from a flop, so out_ready never reaches it combinationally
   assign in_ready = rdy_q;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld;
      skid_d     = skid_q;
      skid_vld_d = skid_vld;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (main_free) begin
         if (skid_vld) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = accept;
            if (accept) begin
               skid_d = in_ent;
            end
         end else begin
            main_vld_d = accept;
            if (accept) begin
               main_d = in_ent;
            end
         end
      end else if (accept) begin
         skid_d     = in_ent;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q   <= '0;
         main_vld <= 1'b0;
         skid_q   <= '0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         main_q   <= main_d;
         main_vld <= main_vld_d;
         skid_q   <= skid_d;
         skid_vld <= skid_vld_d;
         rdy_q    <= !skid_vld_d;
      end
   end

   assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
`else
   assign in_ready = main_free;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld;
      if (flush) begin
         main_vld_d = 1'b0;
      end else if (main_free) begin
         main_vld_d = accept;
         if (accept) begin
            main_d = in_ent;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q   <= '0;
         main_vld <= 1'b0;
      end else begin
         main_q   <= main_d;
         main_vld <= main_vld_d;
      end
   end

   assign occupancy = {1'b0, main_vld};
`endif

   // Stale payload stays in the flops; the outputs are masked to a bubble instead.
   assign out_valid = main_vld;
   assign out_instr = main_vld ? main_q.instr : BUBBLE_INSTR;
   assign out_pc    = main_vld ? main_q.pc    : 32'h0;
   assign out_data  = main_vld ? main_q.data  : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, streaming and async-reset sequences, then random traffic vs a queue model.
module tb_pipe_stage_reg;

   localparam int          PW     = 102;
   localparam logic [31:0] BUBBLE = 32'h0000_0013;
   localparam logic [31:0] INSTR  = 32'h2401_0001;
`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic [31:0]   in_pc;
   logic [PW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
   logic [PW-1:0] out_data;
   logic [1:0]    occupancy;

   pipe_stage_reg #(.PAYLOAD_W(PW), .BUBBLE_INSTR(BUBBLE)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [PW-1:0] data;
   } entry_t;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [31:0] pc;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [1:0]  e_occ;
      logic        e_irdy;
   } vec_t;

   entry_t model_q[$];
   bit     rdy_blocked;
   int     vectors;
   int     miscompares;
   vec_t   tbl[11];

   function automatic logic [PW-1:0] data_of(input logic [31:0] pc);
      return {6'h2a, pc, ~pc, pc ^ 32'h5a5a_5a5a};
   endfunction

   // Capacity 2 with a registered ready (held low until the first edge after reset), else capacity 1 with pass-through ready.
   function automatic logic exp_in_ready();
      if (SKID) return !rdy_blocked && (model_q.size() < 2);
      return (model_q.size() == 0) || out_ready;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      bit     have;
      entry_t h;
      have = model_q.size() > 0;
      h    = have ? model_q[0] : '0;
      chk("out_valid", 128'(out_valid), 128'(have));
      chk("out_instr", 128'(out_instr), 128'(have ? h.instr : BUBBLE));
      chk("out_pc",    128'(out_pc),    128'(h.pc));
      chk("out_data",  128'(out_data),  128'(h.data));
      chk("occupancy", 128'(occupancy), 128'(model_q.size()));
      chk("in_ready",  128'(in_ready),  128'(exp_in_ready()));
   endtask

   // One clock: drive at posedge+1, check at the falling edge, advance the model at the rising edge.
   task automatic cycle(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [PW-1:0] data, input logic ordy, input logic fl);
      bit     acc;
      bit     ret;
      entry_t e;
      in_valid  = iv;
      in_instr  = instr;
      in_pc     = pc;
      in_data   = data;
      out_ready = ordy;
      flush     = fl;
      #4;
      check_model();
      acc     = iv && exp_in_ready();
      ret     = (model_q.size() > 0) && ordy;
      e.instr = instr;
      e.pc    = pc;
      e.data  = data;
      @(posedge clk);
      if (fl) begin
         model_q.delete();
      end else begin
         if (ret) void'(model_q.pop_front());
         if (acc) model_q.push_back(e);
      end
      rdy_blocked = 1'b0;
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rdy_blocked = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      in_instr    = '0;
      in_pc       = '0;
      in_data     = '0;
      out_ready   = 1'b0;

      //          iv    ordy  fl    pc            ov    out_pc        occ              irdy
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0,            1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h3000,     1'b1, 32'h3000,     2'd1,            1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0,            1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h3000,     1'b1, 32'h3000,     2'd1,            SKID};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h3004,     1'b1, 32'h3000,     SKID ? 2'd2 : 2'd1, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        SKID, SKID ? 32'h3004 : 32'h0, SKID ? 2'd1 : 2'd0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0,            1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h3000,     1'b1, 32'h3000,     2'd1,            SKID};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h3004,     1'b1, 32'h3000,     SKID ? 2'd2 : 2'd1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h3008,     1'b0, 32'h0,        2'd0,            1'b1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        2'd0,            1'b1};

      // Reset asserted before any clock edge must clear outputs on its own.
      reset = 1'b1;
      #1 reset = 1'b0;
      #2;
      check_model();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].iv, INSTR, tbl[i].pc, data_of(tbl[i].pc), tbl[i].ordy, tbl[i].fl);
         chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_out_pc", i),    128'(out_pc),    128'(tbl[i].e_pc));
         chk($sformatf("tbl%0d_out_instr", i), 128'(out_instr), 128'(tbl[i].e_ov ? INSTR : BUBBLE));
         chk($sformatf("tbl%0d_occupancy", i), 128'(occupancy), 128'(tbl[i].e_occ));
         chk($sformatf("tbl%0d_in_ready", i),  128'(in_ready),  128'(tbl[i].e_irdy));
      end

      // Streaming: each entry must be on the output exactly one edge after it was offered.
      for (int k = 0; k < 100; k++) begin
         cycle(1'b1, INSTR + 32'(k), 32'h3000 + 32'(4 * k), data_of(32'h3000 + 32'(4 * k)), 1'b1, 1'b0);
         chk($sformatf("stream%0d_pc", k),    128'(out_pc),    128'(32'h3000 + 32'(4 * k)));
         chk($sformatf("stream%0d_valid", k), 128'(out_valid), 128'(1'b1));
      end
      cycle(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

      // Reset in the middle of a cycle with the stage full.
      cycle(1'b1, INSTR, 32'h4000, data_of(32'h4000), 1'b0, 1'b0);
      cycle(1'b1, INSTR, 32'h4004, data_of(32'h4004), 1'b0, 1'b0);
      chk("prefill_occupancy", 128'(occupancy), 128'(SKID ? 2'd2 : 2'd1));
      #2 reset = 1'b0;
      #1;
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_instr", 128'(out_instr), 128'(BUBBLE));
      chk("rst_out_pc",    128'(out_pc),    128'(32'h0));
      chk("rst_out_data",  128'(out_data),  128'(0));
      chk("rst_occupancy", 128'(occupancy), 128'(2'd0));
      chk("rst_in_ready",  128'(in_ready),  128'(!SKID));
      model_q.delete();
      rdy_blocked = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;

      for (int n = 0; n < 10000; n++) begin
         logic [31:0] pc;
         pc = $urandom;
         cycle($urandom_range(0, 3) != 0, $urandom, pc,
               PW'({$urandom, $urandom, $urandom, $urandom}),
               $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter: PAYLOAD_W, 102, width of generic stage payload (e.g. V1+V2+E32+A3+b_jump).
REQ-002 SHALL have parameter: BUBBLE_INSTR, 32'h0000_0000, instruction word presented while no valid entry (nop).
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: flush  in  1  synchronous kill of all held entries (bubble insert).
REQ-006 SHALL have port: in_valid  in  1  upstream entry offered.
REQ-007 SHALL have port: in_ready  out  1  stage can accept this cycle.
REQ-008 SHALL have ports: in_instr  in  32, in_pc  in  32, in_data  in  PAYLOAD_W; the upstream entry.
REQ-009 SHALL have port: out_valid  out  1  downstream entry present.
REQ-010 SHALL have port: out_ready  in  1  downstream accepts (deassert = stall).
REQ-011 SHALL have ports: out_instr  out  32, out_pc  out  32, out_data  out  PAYLOAD_W; the downstream entry.
REQ-012 SHALL have port: occupancy  out  2  count of held entries, 0..2.

Function
REQ-013 SHALL accept an entry iff in_valid && in_ready at a clock edge; SHALL retire iff out_valid && out_ready.
REQ-014 SHALL hold entries in a main register (drives out_*) and one skid register.
REQ-015 SHALL present an accepted entry on out_* with out_valid=1 exactly one cycle after acceptance when main is empty or retiring.
REQ-016 SHALL, when main retires or is empty: refill main from skid if skid full (skid from input if accepted that edge), else from input if accepted, else empty.
REQ-017 SHALL, when main is held (out_valid && !out_ready) and an entry is accepted, store it in skid.
REQ-018 SHALL drive in_ready as a registered signal equal to !skid_full; no combinational path out_ready -> in_ready.
REQ-019 SHALL preserve entry order strictly FIFO; no entry lost or duplicated under any in_valid/out_ready pattern.
REQ-020 SHALL drive out_instr=BUBBLE_INSTR, out_pc=0, out_data=0 whenever out_valid=0.
REQ-021 SHALL, on flush at an edge, empty both entries (occupancy=0, out_valid=0, bubble outputs, in_ready=1) next cycle; flush overrides a simultaneous accept and retire, accepted input discarded.
REQ-022 SHALL keep occupancy equal to main_valid + skid_valid at all times.
REQ-023 SHALL hold all state unchanged when in_valid=0, out_ready=0 and flush=0.

Reset
REQ-024 SHALL, while reset=0, immediately force out_valid=0, out_instr=BUBBLE_INSTR, out_pc=0, out_data=0, occupancy=0, in_ready=0 (with skid) independent of clk.
REQ-025 SHALL drive in_ready=1 from the first rising edge after reset deasserts; reset mid-transfer discards all entries.

Configuration
REQ-026 SHALL compile the skid register only when macro PIPE_STAGE_SKID_EN is defined; behaviour as REQ-014..REQ-025.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, hold one entry only: in_ready = !out_valid || out_ready (combinational), occupancy max 1, in_ready=1 during reset; all other rules unchanged.

Verification
REQ-028 SHALL verify: reset release, in_valid=1 pc=0x3000 instr=0x24010001 -> out_valid=1, out_pc=0x3000 on the next edge, occupancy=1.
REQ-029 SHALL verify (SKID_EN): out_ready=0, push pc 0x3000,0x3004 -> occupancy=2, in_ready=0; out_ready=1 -> retire 0x3000 then 0x3004 in order, in_ready=1 one cycle after first retire.
REQ-030 SHALL verify: occupancy=2, flush=1 with in_valid=1 pc=0x3008 -> next cycle occupancy=0, out_instr=BUBBLE_INSTR, out_pc=0, 0x3008 never appears.
REQ-031 SHALL verify: streaming in_valid=out_ready=1 for 100 entries pc 0x3000+4k -> one retire per cycle, latency 1, no gaps, in order.
REQ-032 SHALL verify: reset=0 asserted mid-cycle with occupancy=2 -> outputs bubble before next clk edge; random in_valid/out_ready/flush 10k cycles vs. FIFO reference model, no mismatch, both macro settings.
